rtc_counter: RTL and testbench

Free-running 32-bit RTC time-base counter in the always-on RTC domain. It produces `count_val` and `cnt_en`, which the RTC interrupt generator compares against the match register. It provides a programmable prescaler, a four-phase load handshake for writing a new counter value, and a wrap pulse.

---
 rtl/rtc_pkg.sv | 23 ++
 rtl/rtc_prescaler.sv | 76 +++++++
 rtl/rtc_counter.sv | 157 +++++++++++++++
 tb/tb_rtc_counter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
//
// Shared definitions for the RTC time-base counter:
//   - default widths for the counter and the prescaler reload value
//   - the load-handshake FSM state encoding
// ---------------------------------------------------------------------------
package rtc_pkg;

    // Counter width; the interrupt comparator must use the same width.
    localparam int CNT_W_DEF = 32;

    // Prescaler reload width.
    localparam int PRE_W_DEF = 16;

    // Load handshake FSM. LD_IDLE waits for a request, LD_ACK holds the
    // acknowledge until the requester drops its request.
    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_ACK  = 1'b1
    } ld_state_e;

endpackage : rtc_pkg

// File: rtl/rtc_prescaler.sv
// ---------------------------------------------------------------------------
// rtc_prescaler
//
// Divides the RTC clock down to a count tick. pre_cnt runs from 0 up to the
// programmed divisor-minus-one and then restarts, producing one tick per
// (ctrl_prescale + 1) enabled cycles.
//
// Ports:
//   clk        in   RTC clock
//   rst_n      in   asynchronous active-low reset
//   en         in   registered count enable; 0 holds pre_cnt at 0
//   clr        in   counter load this cycle; restarts pre_cnt, suppresses tick
//   prescale   in   tick divisor minus 1 (0 = tick every cycle)
//   tick_due   out  combinational: the counter advances on this clock edge
//   rtc_tick   out  registered one-cycle pulse aligned with the new count
//   pre_cnt    out  current prescaler phase (observability)
// ---------------------------------------------------------------------------
module rtc_prescaler
    import rtc_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick_due,
    output logic             rtc_tick,
    output logic [PRE_W-1:0] pre_cnt
);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;
    logic             rtc_tick_q;
    logic             rtc_tick_d;
    logic             at_limit;

    // Greater-or-equal rather than equality: if software lowers the divisor
    // below the current phase, the tick fires on the next cycle instead of
    // waiting for pre_cnt to wrap the whole PRE_W range.
    assign at_limit = (pre_cnt_q >= prescale);

    always_comb begin
        pre_cnt_d  = pre_cnt_q;
        rtc_tick_d = 1'b0;
        tick_due   = 1'b0;

        if (!en || clr) begin
            // Disabled or being loaded: restart the phase, no tick. A load
            // therefore gives a full (prescale + 1) period before the next
            // increment.
            pre_cnt_d = '0;
        end else if (at_limit) begin
            pre_cnt_d  = '0;
            tick_due   = 1'b1;
            rtc_tick_d = 1'b1;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q  <= '0;
            rtc_tick_q <= 1'b0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            rtc_tick_q <= rtc_tick_d;
        end
    end

    assign rtc_tick = rtc_tick_q;
    assign pre_cnt  = pre_cnt_q;

endmodule : rtc_prescaler

// File: rtl/rtc_counter.sv
// ---------------------------------------------------------------------------
// rtc_counter
//
// Free-running RTC time-base counter. Counts prescaled ticks while enabled,
// accepts a new value through a four-phase load handshake, and flags the
// all-ones -> 0 wrap. All outputs are registered.
//
// Handshake (four-phase req/ack):
//   1. requester raises ctrl_load_req with ctrl_load_val stable
//   2. the edge that samples req high loads the counter and raises load_ack
//   3. requester drops ctrl_load_req
//   4. the edge that samples req low drops load_ack
//   A request still high while load_ack is high never reloads. Reset drops
//   load_ack at once; the requester must then restart from req = 0.
//
// Ports:
//   i_rtc_ext_clk  in   RTC clock (only clock)
//   rtc_por_rst_n  in   asynchronous active-low power-on reset
//   ctrl_cnt_en    in   count enable level
//   ctrl_prescale  in   tick divisor minus 1
//   ctrl_load_req  in   load request
//   ctrl_load_val  in   value to load, stable while ctrl_load_req is high
//   load_ack       out  load acknowledge
//   cnt_en         out  registered enable (to comparator)
//   count_val      out  current count
//   rtc_tick       out  one-cycle pulse per increment
//   cnt_wrap       out  one-cycle pulse on all-ones -> 0
//   dbg_ld_state   out  load FSM state (0 = LD_IDLE, 1 = LD_ACK)
// ---------------------------------------------------------------------------
module rtc_counter
    import rtc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             i_rtc_ext_clk,
    input  logic             rtc_por_rst_n,
    input  logic             ctrl_cnt_en,
    input  logic [PRE_W-1:0] ctrl_prescale,
    input  logic             ctrl_load_req,
    input  logic [CNT_W-1:0] ctrl_load_val,
    output logic             load_ack,
    output logic             cnt_en,
    output logic [CNT_W-1:0] count_val,
    output logic             rtc_tick,
    output logic             cnt_wrap,
    output logic             dbg_ld_state
);

    // Registers
    ld_state_e        ld_state_q;
    ld_state_e        ld_state_d;
    logic             load_ack_q;
    logic             load_ack_d;
    logic             cnt_en_q;
    logic             cnt_en_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             cnt_wrap_q;
    logic             cnt_wrap_d;

    // Internal
    logic             load_fire;
    logic             tick_due;
    logic [PRE_W-1:0] pre_cnt;

    // -----------------------------------------------------------------------
    // Prescaler: gated by the registered enable, restarted by a load.
    // -----------------------------------------------------------------------
    rtc_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (i_rtc_ext_clk),
        .rst_n    (rtc_por_rst_n),
        .en       (cnt_en_q),
        .clr      (load_fire),
        .prescale (ctrl_prescale),
        .tick_due (tick_due),
        .rtc_tick (rtc_tick),
        .pre_cnt  (pre_cnt)
    );

    // -----------------------------------------------------------------------
    // Load FSM: next state and handshake outputs.
    // -----------------------------------------------------------------------
    always_comb begin
        ld_state_d = ld_state_q;
        load_ack_d = load_ack_q;
        load_fire  = 1'b0;

        case (ld_state_q)
            LD_IDLE: begin
                if (ctrl_load_req) begin
                    load_fire  = 1'b1;
                    load_ack_d = 1'b1;
                    ld_state_d = LD_ACK;
                end
            end
            LD_ACK: begin
                if (!ctrl_load_req) begin
                    load_ack_d = 1'b0;
                    ld_state_d = LD_IDLE;
                end
            end
            default: begin
                load_ack_d = 1'b0;
                ld_state_d = LD_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Enable register, counter and wrap detect.
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_en_d   = ctrl_cnt_en;
        count_d    = count_q;
        cnt_wrap_d = 1'b0;

        // A load takes priority over a due tick; the prescaler already
        // suppresses tick_due when load_fire is high, so the two branches
        // are exclusive. Loading all-ones therefore never flags a wrap until
        // a later tick actually rolls the count over.
        if (load_fire) begin
            count_d = ctrl_load_val;
        end else if (tick_due) begin
            count_d    = count_q + CNT_W'(1);
            cnt_wrap_d = (count_q == {CNT_W{1'b1}});
        end
    end

    always_ff @(posedge i_rtc_ext_clk or negedge rtc_por_rst_n) begin
        if (!rtc_por_rst_n) begin
            ld_state_q <= LD_IDLE;
            load_ack_q <= 1'b0;
            cnt_en_q   <= 1'b0;
            count_q    <= '0;
            cnt_wrap_q <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            load_ack_q <= load_ack_d;
            cnt_en_q   <= cnt_en_d;
            count_q    <= count_d;
            cnt_wrap_q <= cnt_wrap_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign load_ack     = load_ack_q;
    assign cnt_en       = cnt_en_q;
    assign count_val    = count_q;
    assign cnt_wrap     = cnt_wrap_q;
    assign dbg_ld_state = ld_state_q;

endmodule : rtc_counter

// File: tb/tb_rtc_counter.sv
// ---------------------------------------------------------------------------
// tb_rtc_counter
//
// Directed scenarios followed by randomized traffic. Each clock edge the
// driver advances a behavioural model of the counter and queues the expected
// registered outputs; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_rtc_counter;
    import rtc_pkg::*;

    localparam int CNT_W = 32;
    localparam int PRE_W = 16;
    localparam int EXP_W = CNT_W + 4;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic i_rtc_ext_clk = 1'b0;
    logic rtc_por_rst_n = 1'b0;

    always #5 i_rtc_ext_clk = ~i_rtc_ext_clk;

    // -----------------------------------------------------------------------
    // DUT
    // -----------------------------------------------------------------------
    logic             ctrl_cnt_en   = 1'b0;
    logic [PRE_W-1:0] ctrl_prescale = '0;
    logic             ctrl_load_req = 1'b0;
    logic [CNT_W-1:0] ctrl_load_val = '0;
    logic             load_ack;
    logic             cnt_en;
    logic [CNT_W-1:0] count_val;
    logic             rtc_tick;
    logic             cnt_wrap;
    logic             dbg_ld_state;

    rtc_counter #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) dut (
        .i_rtc_ext_clk (i_rtc_ext_clk),
        .rtc_por_rst_n (rtc_por_rst_n),
        .ctrl_cnt_en   (ctrl_cnt_en),
        .ctrl_prescale (ctrl_prescale),
        .ctrl_load_req (ctrl_load_req),
        .ctrl_load_val (ctrl_load_val),
        .load_ack      (load_ack),
        .cnt_en        (cnt_en),
        .count_val     (count_val),
        .rtc_tick      (rtc_tick),
        .cnt_wrap      (cnt_wrap),
        .dbg_ld_state  (dbg_ld_state)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Behavioural model: what the outputs read after each edge.
    logic             m_en   = 1'b0;
    logic             m_ack  = 1'b0;
    logic             m_tick = 1'b0;
    logic             m_wrap = 1'b0;
    int unsigned      m_pre  = 0;
    logic [CNT_W-1:0] m_cnt  = '0;

    function automatic void model_reset();
        m_en   = 1'b0;
        m_ack  = 1'b0;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        m_pre  = 0;
        m_cnt  = '0;
    endfunction

    // One clock edge of the model, from the current inputs.
    function automatic void model_edge();
        bit load;
        bit tick;
        if (!rtc_por_rst_n) begin
            model_reset();
            return;
        end
        load   = ctrl_load_req && !m_ack;
        tick   = m_en && !load && (m_pre >= int'(ctrl_prescale));
        m_wrap = tick && (m_cnt == {CNT_W{1'b1}});
        m_tick = tick;
        if (load)
            m_cnt = ctrl_load_val;
        else if (tick)
            m_cnt = m_cnt + 1;
        m_pre = (!m_en || load || tick) ? 0 : m_pre + 1;
        if (load)
            m_ack = 1'b1;
        else if (!ctrl_load_req)
            m_ack = 1'b0;
        m_en = ctrl_cnt_en;
    endfunction

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    // Inputs are set at negedge+1; step models the coming posedge, queues the
    // expectation and returns at the following negedge+1.
    task automatic step();
        model_edge();
        exp_q.push_back({m_ack, m_en, m_tick, m_wrap, m_cnt});
        @(negedge i_rtc_ext_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    logic [EXP_W-1:0] mon_exp;
    logic [EXP_W-1:0] mon_act;

    always @(negedge i_rtc_ext_clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {load_ack, cnt_en, rtc_tick, cnt_wrap, count_val};
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL scoreboard @%0t: got ack=%b en=%b tick=%b wrap=%b cnt=%h, expected ack=%b en=%b tick=%b wrap=%b cnt=%h",
                         $time, mon_act[EXP_W-1], mon_act[EXP_W-2], mon_act[EXP_W-3],
                         mon_act[EXP_W-4], mon_act[CNT_W-1:0],
                         mon_exp[EXP_W-1], mon_exp[EXP_W-2], mon_exp[EXP_W-3],
                         mon_exp[EXP_W-4], mon_exp[CNT_W-1:0]);
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1);
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int gap;

        // Reset held for a few cycles.
        repeat (3) step();
        chk("reset_count", count_val, '0);
        chk("reset_flags", {28'd0, load_ack, cnt_en, rtc_tick, cnt_wrap}, '0);
        chk("reset_state", {31'd0, dbg_ld_state}, {31'd0, LD_IDLE});
        rtc_por_rst_n = 1'b1;
        step();

        // Enable with prescale 0: count 1,2,3 with tick every cycle.
        ctrl_cnt_en   = 1'b1;
        ctrl_prescale = 16'd0;
        step();
        chk("en_latency", {31'd0, cnt_en}, 32'd1);
        step();
        chk("count_1", count_val, 32'd1);
        step();
        chk("count_2", count_val, 32'd2);
        step();
        chk("count_3", count_val, 32'd3);
        chk("tick_p0", {31'd0, rtc_tick}, 32'd1);

        // Prescale 3: each value held 4 cycles.
        ctrl_prescale = 16'd3;
        repeat (13) step();
        // Lower prescale to 1 when the phase sits at 3: tick on next edge.
        gap = 0;
        while (m_pre != 3 && gap < 10) begin
            step();
            gap++;
        end
        chk("phase_found", 32'(m_pre), 32'd3);
        ctrl_prescale = 16'd1;
        step();
        chk("lowered_prescale_tick", {31'd0, rtc_tick}, 32'd1);
        repeat (4) step();

        // Load handshake with counting stopped.
        ctrl_cnt_en = 1'b0;
        step();
        step();
        ctrl_load_req = 1'b1;
        ctrl_load_val = 32'h1234_5678;
        step();
        chk("load_ack_rise", {31'd0, load_ack}, 32'd1);
        chk("load_value", count_val, 32'h1234_5678);
        ctrl_load_val = 32'h1234_5678;
        repeat (5) step();
        chk("no_reload_ack", {31'd0, load_ack}, 32'd1);
        chk("no_reload_state", {31'd0, dbg_ld_state}, {31'd0, LD_ACK});
        ctrl_load_req = 1'b0;
        step();
        chk("load_ack_fall", {31'd0, load_ack}, 32'd0);

        // Wrap: load all-ones, then count with prescale 0.
        ctrl_load_req = 1'b1;
        ctrl_load_val = 32'hFFFF_FFFF;
        ctrl_prescale = 16'd0;
        step();
        chk("load_ones", count_val, 32'hFFFF_FFFF);
        chk("load_ones_nowrap", {31'd0, cnt_wrap}, 32'd0);
        ctrl_load_req = 1'b0;
        step();
        ctrl_cnt_en = 1'b1;
        step();
        step();
        chk("wrap_count", count_val, 32'd0);
        chk("wrap_pulse", {31'd0, cnt_wrap}, 32'd1);
        step();
        chk("wrap_one_cycle", {31'd0, cnt_wrap}, 32'd0);

        // Load colliding with a due tick (prescale 3).
        ctrl_prescale = 16'd3;
        gap = 0;
        while (m_pre != 3 && gap < 10) begin
            step();
            gap++;
        end
        ctrl_load_req = 1'b1;
        ctrl_load_val = 32'h10;
        step();
        chk("collide_count", count_val, 32'h10);
        chk("collide_no_tick", {31'd0, rtc_tick}, 32'd0);
        ctrl_load_req = 1'b0;
        gap = 0;
        do begin
            step();
            gap++;
        end while (!rtc_tick && gap < 10);
        chk("collide_next_tick_gap", gap, 32'd4);
        chk("collide_next_count", count_val, 32'h11);

        // Reset while load_ack is high.
        ctrl_load_req = 1'b1;
        ctrl_load_val = $urandom;
        step();
        chk("mid_ack_up", {31'd0, load_ack}, 32'd1);
        rtc_por_rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_count", count_val, '0);
        chk("async_rst_flags", {28'd0, load_ack, cnt_en, rtc_tick, cnt_wrap}, '0);
        chk("async_rst_state", {31'd0, dbg_ld_state}, {31'd0, LD_IDLE});
        ctrl_load_req = 1'b0;
        step();
        step();
        rtc_por_rst_n = 1'b1;
        step();
        ctrl_load_req = 1'b1;
        ctrl_load_val = 32'hCAFE_0001;
        step();
        chk("fresh_ack", {31'd0, load_ack}, 32'd1);
        chk("fresh_value", count_val, 32'hCAFE_0001);
        ctrl_load_req = 1'b0;
        step();
        chk("fresh_ack_fall", {31'd0, load_ack}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0)
                ctrl_cnt_en = ~ctrl_cnt_en;
            if ($urandom_range(0, 19) == 0)
                ctrl_prescale = 16'($urandom_range(0, 4));
            if (!ctrl_load_req && !m_ack && $urandom_range(0, 11) == 0) begin
                ctrl_load_req = 1'b1;
                case ($urandom_range(0, 2))
                    0: ctrl_load_val = $urandom;
                    1: ctrl_load_val = 32'hFFFF_FFFF;
                    default: ctrl_load_val = 32'hFFFF_FFFE;
                endcase
            end else if (ctrl_load_req && m_ack && $urandom_range(0, 2) == 0) begin
                ctrl_load_req = 1'b0;
            end
            if ($urandom_range(0, 199) == 0) begin
                rtc_por_rst_n = 1'b0;
                ctrl_load_req = 1'b0;
                step();
                rtc_por_rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rtc_counter
